encoder_load_store_shift: RTL and testbench

Instruction encoder and emitter for lw, sw, sll, slli, srl, srli, sra and srai. It takes field-level requests (op, registers, immediate) over a valid/ready handshake, range-checks them, and packs them into RV32I words. Encoded words go into a small FIFO and stream out over a second valid/ready handshake. It feeds instruction memory or the decoder in self-check and program-generation benches and in the boot-loader path.

---
 rtl/encoder_load_store_shift_pkg.sv | 47 ++++
 rtl/encoder_load_store_shift_sync_fifo.sv | 55 +++++
 rtl/encoder_load_store_shift.sv | 141 ++++++++++++++
 tb/tb_encoder_load_store_shift.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_load_store_shift_pkg.sv
// Shared types and encoding constants for the load/store/shift instruction encoder.
package ls_shift_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned ERR_W  = 2;

  typedef enum logic [OP_W-1:0] {
    LW   = 3'd0,
    SW   = 3'd1,
    SLL  = 3'd2,
    SLLI = 3'd3,
    SRL  = 3'd4,
    SRLI = 3'd5,
    SRA  = 3'd6,
    SRAI = 3'd7
  } ls_op_e;

  typedef enum logic [ERR_W-1:0] {
    NONE        = 2'd0,
    IMM_RANGE   = 2'd1,
    SHAMT_RANGE = 2'd2
  } ls_err_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_LW_SW = 3'b010;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_SR    = 3'b101;

  localparam logic [6:0] F7_LOGIC = 7'b0000000;
  localparam logic [6:0] F7_ARITH = 7'b0100000;

  // Field-level request payload as presented on the request handshake.
  typedef struct packed {
    ls_op_e           op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
  } ls_req_t;

endpackage

// File: rtl/encoder_load_store_shift_sync_fifo.sv
// Synchronous FIFO with flush; head entry is shown combinationally, zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_occ;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (r_occ == '0);
  assign full_o  = (r_occ == CW'(DEPTH));
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage write; contents are only visible through valid occupancy, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i && !flush_i) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/encoder_load_store_shift.sv
// Encodes lw/sw/shift requests into RV32I words and streams them out through a FIFO.
module encoder_load_store_shift
  import ls_shift_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [4:0]       req_rs1_i,
  input  logic [4:0]       req_rs2_i,
  input  logic [4:0]       req_rd_i,
  input  logic [31:0]      req_imm_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] count_o
);

  ls_req_t         w_req;
  logic            w_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_imm_ok;
  logic            w_shamt_ok;
  logic            w_fail;
  ls_err_e         w_err_code;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_instr;

  logic             r_err;
  ls_err_e          r_err_code;
  logic [CNT_W-1:0] r_count;

  assign w_req.op  = ls_op_e'(req_op_i);
  assign w_req.rs1 = req_rs1_i;
  assign w_req.rs2 = req_rs2_i;
  assign w_req.rd  = req_rd_i;
  assign w_req.imm = req_imm_i;

  assign req_ready_o = !w_full && !flush_i;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_push      = w_accept && !w_fail;
  assign w_pop       = instr_valid_o && instr_ready_i && !flush_i;

  // Offsets must sign-extend from bit 11; shift amounts must fit in 5 bits.
  assign w_imm_ok   = (&w_req.imm[31:11]) || (~|w_req.imm[31:11]);
  assign w_shamt_ok = ~|w_req.imm[31:5];

  // Shift direction picks funct3, arithmetic right shifts pick funct7.
  assign w_f3 = ((w_req.op == SLL) || (w_req.op == SLLI)) ? F3_SLL : F3_SR;
  assign w_f7 = ((w_req.op == SRA) || (w_req.op == SRAI)) ? F7_ARITH : F7_LOGIC;

  // Instruction packing and range check for the presented request.
  always_comb begin
    w_instr    = '0;
    w_fail     = 1'b0;
    w_err_code = NONE;
    case (w_req.op)
      LW: begin
        w_instr = {w_req.imm[11:0], w_req.rs1, F3_LW_SW, w_req.rd, OPC_LOAD};
        if (!w_imm_ok) begin
          w_fail     = 1'b1;
          w_err_code = IMM_RANGE;
        end
      end
      SW: begin
        w_instr = {w_req.imm[11:5], w_req.rs2, w_req.rs1, F3_LW_SW,
                   w_req.imm[4:0], OPC_STORE};
        if (!w_imm_ok) begin
          w_fail     = 1'b1;
          w_err_code = IMM_RANGE;
        end
      end
      SLL, SRL, SRA: begin
        w_instr = {w_f7, w_req.rs2, w_req.rs1, w_f3, w_req.rd, OPC_OP};
      end
      SLLI, SRLI, SRAI: begin
        w_instr = {w_f7, w_req.imm[4:0], w_req.rs1, w_f3, w_req.rd, OPC_OP_IMM};
        if (!w_shamt_ok) begin
          w_fail     = 1'b1;
          w_err_code = SHAMT_RANGE;
        end
      end
      default: begin
        w_instr = '0;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (w_push),
    .data_i  (w_instr),
    .pop_i   (w_pop),
    .data_o  (instr_o),
    .empty_o (w_empty),
    .full_o  (w_full)
  );

  assign instr_valid_o = !w_empty;

  // Error pulse for a rejected request; the code sticks until the next error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err      <= 1'b0;
      r_err_code <= NONE;
    end else begin
      r_err <= w_accept && w_fail;
      if (w_accept && w_fail) r_err_code <= w_err_code;
    end
  end

  // Saturating count of words handed to the consumer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (w_pop && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign err_o      = r_err;
  assign err_code_o = r_err_code;
  assign count_o    = r_count;

endmodule

// File: tb/tb_encoder_load_store_shift.sv
// Scoreboard bench for the load/store/shift encoder.
module tb_encoder_load_store_shift;
  import ls_shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        req_valid_i;
  logic [2:0]  req_op_i;
  logic [4:0]  req_rs1_i;
  logic [4:0]  req_rs2_i;
  logic [4:0]  req_rd_i;
  logic [31:0] req_imm_i;
  logic        instr_ready_i;
  logic        req_ready_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [15:0] count_o;

  // Second instance with a 2-bit counter for saturation.
  logic        s_valid;
  logic        s_ready;
  logic        s_flush;
  logic        s_req_ready;
  logic        s_instr_valid;
  logic [31:0] s_instr;
  logic        s_err;
  logic [1:0]  s_err_code;
  logic [1:0]  s_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  encoder_load_store_shift #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .req_rd_i(req_rd_i), .req_imm_i(req_imm_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
    .err_o(err_o), .err_code_o(err_code_o), .count_o(count_o)
  );

  encoder_load_store_shift #(.FIFO_DEPTH(4), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .flush_i(s_flush),
    .req_valid_i(s_valid), .req_ready_o(s_req_ready),
    .req_op_i(3'd0), .req_rs1_i(5'd0), .req_rs2_i(5'd0),
    .req_rd_i(5'd0), .req_imm_i(32'd0),
    .instr_valid_o(s_instr_valid), .instr_ready_i(s_ready), .instr_o(s_instr),
    .err_o(s_err), .err_code_o(s_err_code), .count_o(s_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake pops and compares the oldest expected word.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_i && !flush_i && instr_valid_o && instr_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%08h expected none", instr_o);
      end else begin
        e = exp_q.pop_front();
        check("word_order", instr_o, e);
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic [31:0] im,
                      input bit ok, input logic [31:0] w);
    int n;
    n = 0;
    req_op_i = o; req_rs1_i = a; req_rs2_i = b; req_rd_i = d; req_imm_i = im;
    req_valid_i = 1'b1;
    @(negedge clk);
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: req_ready_o=0 required 1");
      req_valid_i = 1'b0;
      return;
    end
    if (ok) exp_q.push_back(w);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || instr_valid_o) && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (exp_q.size() != 0 || instr_valid_o) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words left expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; instr_ready_i = 1'b0;
    req_op_i = '0; req_rs1_i = '0; req_rs2_i = '0; req_rd_i = '0; req_imm_i = '0;
    s_valid = 1'b0; s_ready = 1'b1; s_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_code", 32'(err_code_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Single LW, one-cycle latency, then handshake
    send(LW, 5'd2, 5'd0, 5'd5, 32'hFFFF_FFFC, 1'b1, 32'hFFC1_2283);
    check("lw_latency_valid", 32'(instr_valid_o), 32'd1);
    check("lw_latency_word", instr_o, 32'hFFC1_2283);
    instr_ready_i = 1'b1;
    wait_drain();
    check("count_after_lw", 32'(count_o), 32'd1);

    // Back-to-back SW, SLL, SRAI
    send(SW,   5'd3, 5'd6, 5'd0, 32'd8, 1'b1, 32'h0061_A423);
    send(SLL,  5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h0020_91B3);
    send(SRAI, 5'd1, 5'd0, 5'd1, 32'd3, 1'b1, 32'h4030_D093);
    wait_drain();
    check("count_after_b2b", 32'(count_o), 32'd4);

    // Range errors
    send(SLLI, 5'd1, 5'd0, 5'd1, 32'd32, 1'b0, 32'd0);
    check("shamt_err_pulse", 32'(err_o), 32'd1);
    check("shamt_err_code", 32'(err_code_o), 32'd2);
    check("shamt_no_word", 32'(instr_valid_o), 32'd0);
    @(posedge clk); #1;
    check("err_pulse_ends", 32'(err_o), 32'd0);
    check("err_code_holds", 32'(err_code_o), 32'd2);
    check("count_after_err", 32'(count_o), 32'd4);
    send(LW, 5'd1, 5'd0, 5'd1, 32'd2048, 1'b0, 32'd0);
    check("imm_err_pulse", 32'(err_o), 32'd1);
    check("imm_err_code", 32'(err_code_o), 32'd1);
    check("imm_no_word", 32'(instr_valid_o), 32'd0);
    send(LW, 5'd0, 5'd0, 5'd1, 32'hFFFF_F800, 1'b1, 32'h8000_2083);
    check("min_imm_no_err", 32'(err_o), 32'd0);
    wait_drain();
    check("count_after_min_imm", 32'(count_o), 32'd5);
    check("err_code_sticky", 32'(err_code_o), 32'd1);

    // Backpressure: fill the FIFO
    instr_ready_i = 1'b0;
    send(SW,   5'd3, 5'd6, 5'd0, 32'd8,          1'b1, 32'h0061_A423);
    send(LW,   5'd2, 5'd0, 5'd5, 32'hFFFF_FFFC,  1'b1, 32'hFFC1_2283);
    send(SLL,  5'd1, 5'd2, 5'd3, 32'd0,          1'b1, 32'h0020_91B3);
    send(SRAI, 5'd1, 5'd0, 5'd1, 32'd3,          1'b1, 32'h4030_D093);
    check("full_not_ready", 32'(req_ready_o), 32'd0);
    check("full_head", instr_o, 32'h0061_A423);
    repeat (3) @(posedge clk);
    #1;
    check("head_stable", instr_o, 32'h0061_A423);
    check("full_still_valid", 32'(instr_valid_o), 32'd1);
    instr_ready_i = 1'b1;
    @(posedge clk); #1;
    check("ready_after_pop", 32'(req_ready_o), 32'd1);
    wait_drain();
    check("count_after_bp", 32'(count_o), 32'd9);

    // Flush with two words queued and a request pending
    instr_ready_i = 1'b0;
    send(SLL,  5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h0020_91B3);
    send(SRAI, 5'd1, 5'd0, 5'd1, 32'd3, 1'b1, 32'h4030_D093);
    check("pre_flush_valid", 32'(instr_valid_o), 32'd1);
    req_op_i = LW; req_rs1_i = 5'd0; req_rd_i = 5'd1; req_imm_i = 32'd0;
    req_valid_i = 1'b1;
    flush_i = 1'b1;
    instr_ready_i = 1'b1;
    #1;
    check("flush_blocks_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    instr_ready_i = 1'b0;
    exp_q.delete();
    check("flush_empty", 32'(instr_valid_o), 32'd0);
    check("flush_instr_zero", instr_o, 32'd0);
    check("flush_count", 32'(count_o), 32'd9);
    @(posedge clk); #1;
    check("flush_no_accept", 32'(instr_valid_o), 32'd0);

    // Reset mid-stream with three words queued
    send(LW,  5'd2, 5'd0, 5'd5, 32'hFFFF_FFFC, 1'b1, 32'hFFC1_2283);
    send(SW,  5'd3, 5'd6, 5'd0, 32'd8,         1'b1, 32'h0061_A423);
    send(SLL, 5'd1, 5'd2, 5'd3, 32'd0,         1'b1, 32'h0020_91B3);
    rst_i = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check("mid_rst_valid", 32'(instr_valid_o), 32'd0);
    check("mid_rst_instr", instr_o, 32'd0);
    check("mid_rst_err", 32'(err_o), 32'd0);
    check("mid_rst_code", 32'(err_code_o), 32'd0);
    check("mid_rst_count", 32'(count_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Counter saturation on the 2-bit instance: five handshakes
    s_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sat_count", 32'(s_count), 32'd3);
    check("sat_drained", 32'(s_instr_valid), 32'd0);
    check("sat_instr_zero", s_instr, 32'd0);
    check("sat_no_err", 32'({s_err, s_err_code}), 32'd0);
    check("sat_ready", 32'(s_req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
